ch3_ascii_bcd_parser: RTL and testbench
=======================================

Name: ch3_ascii_bcd_parser

Overview:
- Receive-side counterpart of the text-output digit decoder. Accepts a byte stream of ASCII characters, one per valid/ready handshake, from a keypad or UART front end.
- Converts the digit characters '0'..'9' (8'h30..8'h39) into a packed BCD word of up to DIGITS digits.
- A terminator character delivers the word downstream with a hold-until-acknowledge handshake. Malformed or overlong input is flagged, not silently truncated.

Parameters:
- DIGITS, 4: maximum BCD digits per number; BCD_OUT width = 4*DIGITS.
- TERM_CHAR, 8'h0D: terminator character (CR) that ends a number.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- ASCII_IN  input  8  incoming character code.
- ASCII_VALID  input  1  ASCII_IN is valid this cycle.
- ASCII_READY  output  1  parser can accept a character this cycle.
- BCD_OUT  output  4*DIGITS  packed BCD result; least significant digit in [3:0].
- DIGIT_CNT  output  $clog2(DIGITS+1)  number of digits in BCD_OUT.
- BCD_ERR  output  1  result invalid (bad character or overflow); qualified by BCD_VALID.
- BCD_VALID  output  1  result available; held until acknowledged.
- BCD_ACK  input  1  downstream consumed the result.

Behaviour:
- Reset (async, immediate): state COLLECT, ASCII_READY=1, BCD_OUT=0, DIGIT_CNT=0, BCD_ERR=0, BCD_VALID=0. Reset mid-number or mid-hold discards everything.
- A character is accepted on a rising CLK edge with ASCII_VALID && ASCII_READY. ASCII_IN is ignored otherwise.
- ASCII_READY = 1 in COLLECT and DISCARD, 0 in HOLD. It is a registered-state decode, not combinational from ASCII_VALID.
- COLLECT:
  - Digit with DIGIT_CNT < DIGITS: BCD_OUT <= {BCD_OUT[4*DIGITS-5:0], ASCII_IN[3:0]}; DIGIT_CNT +1. Leading zeros are kept ("007" gives 12'h007, DIGIT_CNT=3).
  - Digit with DIGIT_CNT == DIGITS: overflow; go to DISCARD.
  - TERM_CHAR with DIGIT_CNT > 0: go to HOLD, BCD_ERR=0.
  - TERM_CHAR with DIGIT_CNT == 0: ignored; stay in COLLECT, no output.
  - Any other character: go to DISCARD.
- DISCARD:
  - Every character except TERM_CHAR is consumed and dropped.
  - TERM_CHAR: go to HOLD with BCD_ERR=1, BCD_OUT=0, DIGIT_CNT=0.
- HOLD:
  - BCD_VALID=1. BCD_OUT, DIGIT_CNT and BCD_ERR are stable.
  - BCD_ACK high on an edge: go to COLLECT, clear BCD_OUT, DIGIT_CNT and BCD_ERR, deassert BCD_VALID. ASCII_READY=1 from the next cycle.
  - BCD_ACK outside HOLD is ignored.
- Latency: terminator accepted at edge N gives BCD_VALID=1 after edge N (visible cycle N+1). BCD_ACK at edge M gives ASCII_READY=1 after edge M.
- Throughput: one character per cycle in COLLECT/DISCARD. Back-to-back numbers are limited only by the ACK turnaround.
- Simultaneous ASCII_VALID and BCD_ACK in HOLD: the character is not accepted (ASCII_READY=0). The sender must hold it.
- Character range checks use unsigned compares 8'h30 <= ASCII_IN <= 8'h39. Bit 7 set is always a non-digit.

Optional Feature:
- Macro: CH3_PARSER_BACKSPACE_EN.
- Defined:
  - 8'h08 (BS) in COLLECT with DIGIT_CNT > 0: BCD_OUT <= BCD_OUT >> 4; DIGIT_CNT -1.
  - BS in COLLECT with DIGIT_CNT == 0: ignored.
  - BS in DISCARD: dropped; it does not clear the error.
- Undefined: 8'h08 is an ordinary invalid character and sends COLLECT to DISCARD.

Decomposition:
- Package ch3_char_pkg holds:
  - ASCII constants: ASCII_ZERO 8'h30, ASCII_NINE 8'h39, ASCII_CR 8'h0D, ASCII_BS 8'h08.
  - Parser state encoding: COLLECT, DISCARD, HOLD (2 bits).
- Sub-module ch3_ascii_classify is combinational: ASCII_IN in; IS_DIGIT, IS_TERM, IS_BS and NIBBLE out.
- The FSM, shift register and counter stay in the parent.

Test Plan:
- Reset, then send '1','2','3',CR -> BCD_VALID one cycle after CR, BCD_OUT=16'h0123, DIGIT_CNT=3, BCD_ERR=0. ACK -> ASCII_READY=1 next cycle, outputs cleared.
- Send '9','8','7','6','5',CR (DIGITS=4) -> BCD_VALID with BCD_ERR=1, BCD_OUT=0, DIGIT_CNT=0.
- Send '4','A','2',CR -> BCD_ERR=1. Then send '5',CR after ACK -> BCD_OUT=16'h0005, BCD_ERR=0.
- Send CR alone, then '0','7',CR -> no output for the lone CR; then BCD_OUT=16'h0007, DIGIT_CNT=2.
- Hold BCD_ACK low for 10 cycles in HOLD while ASCII_VALID=1 with '3' -> ASCII_READY=0 throughout, outputs stable, '3' accepted only after ACK.
- Backspace, with CH3_PARSER_BACKSPACE_EN: '1','2',BS,'5',CR -> BCD_OUT=16'h0015, DIGIT_CNT=2.
- Backspace, without the macro: same sequence -> BCD_ERR=1.
- Assert RST mid-number after '1','2', then send '3',CR -> BCD_OUT=16'h0003.

Source files
------------

// File: rtl/ch3_char_pkg.sv
// Character codes and parser state encoding shared by the ASCII-to-BCD parser.
package ch3_char_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_BS   = 8'h08;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } parser_state_e;

endpackage

// File: rtl/ch3_ascii_classify.sv
// Combinational character classifier: digit / terminator / backspace flags and the digit nibble.
module ch3_ascii_classify
  import ch3_char_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = ASCII_CR
) (
  input  logic [7:0] ASCII_IN,
  output logic       IS_DIGIT,
  output logic       IS_TERM,
  output logic       IS_BS,
  output logic [3:0] NIBBLE
);

  // Unsigned range compare, so anything with bit 7 set falls outside.
  assign IS_DIGIT = (ASCII_IN >= ASCII_ZERO) && (ASCII_IN <= ASCII_NINE);
  assign IS_TERM  = (ASCII_IN == TERM_CHAR);
  assign IS_BS    = (ASCII_IN == ASCII_BS);
  assign NIBBLE   = ASCII_IN[3:0];

endmodule

// File: rtl/ch3_ascii_bcd_parser.sv
// ASCII digit stream to packed BCD word with hold-until-ack result handshake.
// Optional backspace editing is enabled by defining CH3_PARSER_BACKSPACE_EN.
module ch3_ascii_bcd_parser
  import ch3_char_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter logic [7:0]  TERM_CHAR = ASCII_CR
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [7:0]                     ASCII_IN,
  input  logic                           ASCII_VALID,
  output logic                           ASCII_READY,
  output logic [4*DIGITS-1:0]            BCD_OUT,
  output logic [$clog2(DIGITS+1)-1:0]    DIGIT_CNT,
  output logic                           BCD_ERR,
  output logic                           BCD_VALID,
  input  logic                           BCD_ACK
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DIGITS);

  parser_state_e    state_q, state_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ready_q, valid_q;

  logic       is_digit, is_term, is_bs;
  logic [3:0] nibble;
  logic       accept;

  ch3_ascii_classify #(
    .TERM_CHAR (TERM_CHAR)
  ) u_classify (
    .ASCII_IN (ASCII_IN),
    .IS_DIGIT (is_digit),
    .IS_TERM  (is_term),
    .IS_BS    (is_bs),
    .NIBBLE   (nibble)
  );

  assign accept = ASCII_VALID && ready_q;

`ifndef CH3_PARSER_BACKSPACE_EN
  // Backspace is an ordinary invalid character here and falls into the catch-all branch.
  logic unused_bs;
  assign unused_bs = is_bs;
`endif

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_q < MAX_CNT) begin
              bcd_d = {bcd_q[BCD_W-5:0], nibble};
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              state_d = DISCARD;
              bcd_d   = '0;
              cnt_d   = '0;
            end
          end else if (is_term) begin
            if (cnt_q != '0) begin
              state_d = HOLD;
              err_d   = 1'b0;
            end
          end
`ifdef CH3_PARSER_BACKSPACE_EN
          else if (is_bs) begin
            if (cnt_q != '0) begin
              bcd_d = bcd_q >> 4;
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
`endif
          else begin
            state_d = DISCARD;
            bcd_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      DISCARD: begin
        // Everything up to the terminator is dropped; the terminator reports the error.
        if (accept && is_term) begin
          state_d = HOLD;
          err_d   = 1'b1;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (BCD_ACK) begin
          state_d = COLLECT;
          bcd_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = COLLECT;
        bcd_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= COLLECT;
      bcd_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= (state_d != HOLD);
      valid_q <= (state_d == HOLD);
    end
  end

  assign ASCII_READY = ready_q;
  assign BCD_VALID   = valid_q;
  assign BCD_OUT     = bcd_q;
  assign DIGIT_CNT   = cnt_q;
  assign BCD_ERR     = err_q;

endmodule

// File: tb/tb_ch3_ascii_bcd_parser.sv
// Directed bench for ch3_ascii_bcd_parser with a queue-based reference model checked every cycle.
module tb_ch3_ascii_bcd_parser;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [7:0]       ASCII_IN = 8'h00;
  logic             ASCII_VALID = 1'b0;
  logic             BCD_ACK = 1'b0;
  logic             ASCII_READY;
  logic [BCD_W-1:0] BCD_OUT;
  logic [CNT_W-1:0] DIGIT_CNT;
  logic             BCD_ERR;
  logic             BCD_VALID;

  int checks = 0;
  int failures = 0;

  ch3_ascii_bcd_parser #(.DIGITS(DIGITS)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ASCII_IN    (ASCII_IN),
    .ASCII_VALID (ASCII_VALID),
    .ASCII_READY (ASCII_READY),
    .BCD_OUT     (BCD_OUT),
    .DIGIT_CNT   (DIGIT_CNT),
    .BCD_ERR     (BCD_ERR),
    .BCD_VALID   (BCD_VALID),
    .BCD_ACK     (BCD_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digits kept as a list of integers, result built arithmetically.
  int          m_digs[$];
  bit          m_bad  = 1'b0;
  bit          m_hold = 1'b0;
  logic [15:0] m_out  = 16'h0;
  int          m_cnt  = 0;
  bit          m_err  = 1'b0;

  task automatic model_char(input logic [7:0] c);
    bit dig;
    dig = (c >= 8'h30) && (c <= 8'h39);
    if (m_bad) begin
      if (c == 8'h0D) begin
        m_hold = 1'b1; m_err = 1'b1; m_out = 16'h0; m_cnt = 0;
        m_bad = 1'b0; m_digs.delete();
      end
    end else if (dig) begin
      if (m_digs.size() < DIGITS) m_digs.push_back(int'(c) - 48);
      else m_bad = 1'b1;
    end else if (c == 8'h0D) begin
      if (m_digs.size() > 0) begin
        m_hold = 1'b1; m_err = 1'b0; m_cnt = m_digs.size(); m_out = 16'h0;
        foreach (m_digs[i]) m_out = 16'(m_out * 16 + m_digs[i]);
        m_digs.delete();
      end
    end
`ifdef CH3_PARSER_BACKSPACE_EN
    else if (c == 8'h08) begin
      if (m_digs.size() > 0) void'(m_digs.pop_back());
    end
`endif
    else begin
      m_bad = 1'b1;
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_digs.delete(); m_bad = 1'b0; m_hold = 1'b0;
      m_out = 16'h0; m_cnt = 0; m_err = 1'b0;
    end else if (m_hold) begin
      if (BCD_ACK) begin
        m_hold = 1'b0; m_out = 16'h0; m_cnt = 0; m_err = 1'b0;
      end
    end else if (ASCII_VALID) begin
      model_char(ASCII_IN);
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("cyc_ready", 32'(ASCII_READY), 32'(!m_hold));
      chk("cyc_valid", 32'(BCD_VALID), 32'(m_hold));
      if (m_hold) begin
        chk("cyc_bcd_out", 32'(BCD_OUT), 32'(m_out));
        chk("cyc_digit_cnt", 32'(DIGIT_CNT), 32'(m_cnt));
        chk("cyc_bcd_err", 32'(BCD_ERR), 32'(m_err));
      end
    end
  end

  task automatic send(input logic [7:0] c);
    int   n;
    logic r;
    n = 0;
    ASCII_IN = c;
    ASCII_VALID = 1'b1;
    do begin
      r = ASCII_READY;
      @(posedge CLK); #1;
      n++;
    end while (!r && n < 50);
    chk("send_accept", 32'(r), 32'd1);
    ASCII_VALID = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(8'(s[i]));
  endtask

  task automatic do_ack();
    BCD_ACK = 1'b1;
    @(posedge CLK); #1;
    BCD_ACK = 1'b0;
    chk("ack_ready", 32'(ASCII_READY), 32'd1);
    chk("ack_valid", 32'(BCD_VALID), 32'd0);
    chk("ack_out_clr", 32'(BCD_OUT), 32'd0);
    chk("ack_cnt_clr", 32'(DIGIT_CNT), 32'd0);
    chk("ack_err_clr", 32'(BCD_ERR), 32'd0);
  endtask

  // Called straight after the terminator's accepting edge: valid must already be up.
  task automatic expect_num(input string name, input logic [15:0] out, input int cnt, input bit err);
    chk({name, "_valid"}, 32'(BCD_VALID), 32'd1);
    chk({name, "_ready"}, 32'(ASCII_READY), 32'd0);
    chk({name, "_out"}, 32'(BCD_OUT), 32'(out));
    chk({name, "_cnt"}, 32'(DIGIT_CNT), 32'(cnt));
    chk({name, "_err"}, 32'(BCD_ERR), 32'(err));
    do_ack();
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(ASCII_READY), 32'd1);
    chk("rst_valid", 32'(BCD_VALID), 32'd0);
    chk("rst_out", 32'(BCD_OUT), 32'd0);
    chk("rst_cnt", 32'(DIGIT_CNT), 32'd0);
    chk("rst_err", 32'(BCD_ERR), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    send_str("123\r");
    expect_num("n123", 16'h0123, 3, 1'b0);

    send_str("98765\r");
    expect_num("ovf", 16'h0000, 0, 1'b1);

    send_str("4A2\r");
    expect_num("badch", 16'h0000, 0, 1'b1);
    send_str("5\r");
    expect_num("n5", 16'h0005, 1, 1'b0);

    send(8'h0D);
    chk("lone_cr_valid", 32'(BCD_VALID), 32'd0);
    chk("lone_cr_ready", 32'(ASCII_READY), 32'd1);
    send_str("07\r");
    expect_num("n07", 16'h0007, 2, 1'b0);

    send_str("8\r");
    chk("hold_entry", 32'(BCD_VALID), 32'd1);
    ASCII_IN = 8'h33;
    ASCII_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("hold_ready", 32'(ASCII_READY), 32'd0);
      chk("hold_out", 32'(BCD_OUT), 32'h0008);
      chk("hold_cnt", 32'(DIGIT_CNT), 32'd1);
    end
    BCD_ACK = 1'b1;
    @(posedge CLK); #1;
    BCD_ACK = 1'b0;
    chk("ackvld_ready", 32'(ASCII_READY), 32'd1);
    chk("ackvld_cnt", 32'(DIGIT_CNT), 32'd0);
    @(posedge CLK); #1;
    ASCII_VALID = 1'b0;
    chk("held3_cnt", 32'(DIGIT_CNT), 32'd1);
    send(8'h0D);
    expect_num("held3", 16'h0003, 1, 1'b0);

    send_str("12"); send(8'h08); send_str("5\r");
`ifdef CH3_PARSER_BACKSPACE_EN
    expect_num("bs", 16'h0015, 2, 1'b0);
`else
    expect_num("bs", 16'h0000, 0, 1'b1);
`endif

    send_str("12");
    RST = 1'b1;
    #2;
    chk("midrst_cnt", 32'(DIGIT_CNT), 32'd0);
    chk("midrst_out", 32'(BCD_OUT), 32'd0);
    chk("midrst_ready", 32'(ASCII_READY), 32'd1);
    RST = 1'b0;
    @(posedge CLK); #1;
    send_str("3\r");
    expect_num("postrst", 16'h0003, 1, 1'b0);

    repeat (2) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
